// File: rtl/io_mapper.sv
// CPU I/O window 0x5F80-0x5F9F: DIP/player reads, control latches, sound command
// latch with IRQ handshake, and a watchdog that pulses WDRST when not kicked.
module io_mapper #(
  parameter int unsigned WDOG_LIMIT = 24000000,
  parameter int unsigned WDOG_W     = 25,
  parameter int unsigned WDRST_LEN  = 16
) (
  input  logic       SYSCLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       IOCS,
  input  logic       RWb,
  input  logic [3:0] ADDR,
  input  logic [7:0] DIN,
  input  logic [7:0] DSW1,
  input  logic [7:0] DSW2,
  input  logic [3:0] DSW3,
  input  logic [7:0] P1,
  input  logic [7:0] P2,
  input  logic       SNDACK,
  output logic [7:0] DOUT,
  output logic       DOE,
  output logic       COIN1,
  output logic       COIN2,
  output logic       WOCO,
  output logic       RMRD,
  output logic [7:0] SNDLATCH,
  output logic       SNDIRQ,
  output logic       WDRST
);

  localparam int unsigned PLS_W = (WDRST_LEN > 1) ? $clog2(WDRST_LEN) : 1;
  localparam logic [WDOG_W-1:0] WD_LAST  = WDOG_W'(WDOG_LIMIT - 1);
  localparam logic [WDOG_W-1:0] WD_MAX   = '1;
  localparam logic [PLS_W-1:0]  PLS_LAST = PLS_W'(WDRST_LEN - 1);

  typedef enum logic {WD_RUN = 1'b0, WD_FIRE = 1'b1} wd_state_e;

  logic              ce_d_q;
  logic [7:0]        dout_q, dout_d;
  logic              doe_q, doe_d;
  logic              coin1_q, coin1_d, coin2_q, coin2_d;
  logic              woco_q, woco_d, rmrd_q, rmrd_d;
  logic [7:0]        sndlatch_q, sndlatch_d;
  logic              sndirq_q, sndirq_d;
  wd_state_e         wd_state_q, wd_state_d;
  logic [WDOG_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [PLS_W-1:0]  pls_cnt_q, pls_cnt_d;

  logic       wstb, wr_ctrl, wr_snd;
  logic [7:0] rd_data;

  // One strobe per CPU write: the E falling edge while selected for write.
  assign wstb    = ce_d_q & ~CE & ~IOCS & ~RWb;
  assign wr_ctrl = wstb & (ADDR == 4'h8);
  assign wr_snd  = wstb & (ADDR == 4'hC);

  always_comb begin
    rd_data = 8'hFF;
    case (ADDR)
      4'h0:    rd_data = {4'hF, DSW3};
      4'h1:    rd_data = P1;
      4'h2:    rd_data = P2;
      4'h3:    rd_data = DSW2;
      4'h4:    rd_data = DSW1;
      default: rd_data = 8'hFF;
    endcase
  end

  always_comb begin
    doe_d      = ~IOCS & RWb;
    dout_d     = doe_d ? rd_data : 8'hFF;
    coin1_d    = coin1_q;
    coin2_d    = coin2_q;
    woco_d     = woco_q;
    rmrd_d     = rmrd_q;
    sndlatch_d = sndlatch_q;
    if (wr_ctrl) begin
      coin1_d = DIN[0];
      coin2_d = DIN[1];
      woco_d  = DIN[5];
      rmrd_d  = DIN[6];
    end
    if (wr_snd) sndlatch_d = DIN;
    // A new command outranks an acknowledge arriving in the same cycle.
    sndirq_d = wr_snd | (sndirq_q & ~SNDACK);
  end

  // Watchdog: the control-register write is the kick; kicks in FIRE are ignored.
  always_comb begin
    wd_state_d = wd_state_q;
    wd_cnt_d   = wd_cnt_q;
    pls_cnt_d  = pls_cnt_q;
    case (wd_state_q)
      WD_RUN: begin
        if (wr_ctrl) begin
          wd_cnt_d = '0;
        end else if (wd_cnt_q == WD_LAST) begin
          wd_state_d = WD_FIRE;
          pls_cnt_d  = '0;
        end else if (wd_cnt_q != WD_MAX) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      WD_FIRE: begin
        if (pls_cnt_q == PLS_LAST) begin
          wd_state_d = WD_RUN;
          wd_cnt_d   = '0;
        end else begin
          pls_cnt_d = pls_cnt_q + 1'b1;
        end
      end
      default: wd_state_d = WD_RUN;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      ce_d_q     <= 1'b0;
      dout_q     <= 8'hFF;
      doe_q      <= 1'b0;
      coin1_q    <= 1'b0;
      coin2_q    <= 1'b0;
      woco_q     <= 1'b0;
      rmrd_q     <= 1'b0;
      sndlatch_q <= 8'h00;
      sndirq_q   <= 1'b0;
      wd_state_q <= WD_RUN;
      wd_cnt_q   <= '0;
      pls_cnt_q  <= '0;
    end else begin
      ce_d_q     <= CE;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
      coin1_q    <= coin1_d;
      coin2_q    <= coin2_d;
      woco_q     <= woco_d;
      rmrd_q     <= rmrd_d;
      sndlatch_q <= sndlatch_d;
      sndirq_q   <= sndirq_d;
      wd_state_q <= wd_state_d;
      wd_cnt_q   <= wd_cnt_d;
      pls_cnt_q  <= pls_cnt_d;
    end
  end

  assign DOUT     = dout_q;
  assign DOE      = doe_q;
  assign COIN1    = coin1_q;
  assign COIN2    = coin2_q;
  assign WOCO     = woco_q;
  assign RMRD     = rmrd_q;
  assign SNDLATCH = sndlatch_q;
  assign SNDIRQ   = sndirq_q;
  assign WDRST    = (wd_state_q == WD_FIRE);

endmodule

// File: tb/tb_io_mapper.sv
// Scoreboard bench for io_mapper: stimulus queues expectations, a negedge monitor
// pops read data on DOE and cycle-tagged state expectations as their cycle arrives.
module tb_io_mapper;
  logic       SYSCLK;
  logic       RESET, CE, IOCS, RWb, SNDACK;
  logic [3:0] ADDR, DSW3;
  logic [7:0] DIN, DSW1, DSW2, P1, P2;
  logic [7:0] DOUT, SNDLATCH;
  logic       DOE, COIN1, COIN2, WOCO, RMRD, SNDIRQ, WDRST;

  // Observed vector: {DOUT, DOE, COIN1, COIN2, WOCO, RMRD, SNDLATCH, SNDIRQ, WDRST}
  localparam logic [22:0] M_ALL  = 23'h7FFFFF;
  localparam logic [22:0] M_RD   = 23'h7FC000;
  localparam logic [22:0] M_CTRL = 23'h003C00;
  localparam logic [22:0] M_SND  = 23'h0003FE;
  localparam logic [22:0] M_WD   = 23'h000001;
  localparam logic [22:0] W0     = 23'h000000;
  localparam logic [22:0] W1     = 23'h000001;

  int          cyc = 0;
  int          nchk = 0;
  int          npass = 0;
  int          tq_c[$];
  string       tq_n[$];
  logic [22:0] tq_e[$], tq_m[$];
  logic [7:0]  rq_e[$];
  int          rq_a[$];
  logic [22:0] act;
  logic [3:0]  RD_A [6];
  logic [7:0]  RD_E [6];

  assign act = {DOUT, DOE, COIN1, COIN2, WOCO, RMRD, SNDLATCH, SNDIRQ, WDRST};

  io_mapper #(.WDOG_LIMIT(100), .WDOG_W(7), .WDRST_LEN(4)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .CE(CE), .IOCS(IOCS), .RWb(RWb),
    .ADDR(ADDR), .DIN(DIN), .DSW1(DSW1), .DSW2(DSW2), .DSW3(DSW3),
    .P1(P1), .P2(P2), .SNDACK(SNDACK), .DOUT(DOUT), .DOE(DOE),
    .COIN1(COIN1), .COIN2(COIN2), .WOCO(WOCO), .RMRD(RMRD),
    .SNDLATCH(SNDLATCH), .SNDIRQ(SNDIRQ), .WDRST(WDRST)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  function automatic logic [22:0] mk(input logic [7:0] dout, input logic doe,
                                     input logic c1, input logic c2, input logic wo,
                                     input logic rm, input logic [7:0] sl,
                                     input logic irq, input logic wd);
    return {dout, doe, c1, c2, wo, rm, sl, irq, wd};
  endfunction

  task automatic chk(input string nm, input logic [22:0] a, input logic [22:0] e,
                     input logic [22:0] m);
    nchk++;
    if ((a & m) === (e & m)) npass++;
    else $display("FAIL %s @cyc %0d: got %h want %h (mask %h)", nm, cyc, a & m, e & m, m);
  endtask

  task automatic exp_at(input int c, input string nm, input logic [22:0] e,
                        input logic [22:0] m);
    tq_c.push_back(c); tq_n.push_back(nm); tq_e.push_back(e); tq_m.push_back(m);
  endtask

  // Monitor: state expectations fire on their cycle, read data on each DOE.
  always @(negedge SYSCLK) begin
    for (int i = tq_c.size() - 1; i >= 0; i--) begin
      if (tq_c[i] <= cyc) begin
        if (tq_c[i] == cyc) chk(tq_n[i], act, tq_e[i], tq_m[i]);
        else begin
          nchk++;
          $display("FAIL %s stale: due cyc %0d, now %0d", tq_n[i], tq_c[i], cyc);
        end
        tq_c.delete(i); tq_n.delete(i); tq_e.delete(i); tq_m.delete(i);
      end
    end
    if (DOE === 1'b1) begin
      if (rq_e.size() == 0) begin
        nchk++;
        $display("FAIL rd_unexpected @cyc %0d: got DOE=1 DOUT=%h want DOE=0", cyc, DOUT);
      end else begin
        chk($sformatf("rd_a%0d", rq_a[0]), act, {rq_e[0], 1'b1, 14'h0}, M_RD);
        void'(rq_e.pop_front());
        void'(rq_a.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // One CPU write with a single E falling edge; eff is the cycle its effect is visible.
  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d, input logic ack,
                           output int eff);
    IOCS = 1'b0; RWb = 1'b0; ADDR = a; DIN = d; CE = 1'b1;
    step();
    CE = 1'b0; SNDACK = ack;
    step();
    SNDACK = 1'b0; IOCS = 1'b1; RWb = 1'b1;
    eff = cyc;
  endtask

  initial begin
    int t0, k1, e, c1, c2, c3, t1;
    RESET = 1'b1; CE = 1'b0; IOCS = 1'b1; RWb = 1'b1; ADDR = 4'h0; DIN = 8'h00;
    SNDACK = 1'b0; DSW1 = 8'h3C; DSW2 = 8'hA5; DSW3 = 4'h5; P1 = 8'hFE; P2 = 8'h7F;
    RD_A = '{4'h0, 4'h1, 4'h4, 4'h7, 4'h2, 4'h3};
    RD_E = '{8'hF5, 8'hFE, 8'h3C, 8'hFF, 8'h7F, 8'hA5};

    repeat (3) step();
    exp_at(cyc, "reset", mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0), M_ALL);
    RESET = 1'b0;
    t0 = cyc;

    // Unkicked watchdog: 4-cycle pulse after 100 cycles, period 104.
    exp_at(t0 + 99,  "wd_before",   W0, M_WD);
    exp_at(t0 + 100, "wd_first",    W1, M_WD);
    exp_at(t0 + 103, "wd_last",     W1, M_WD);
    exp_at(t0 + 104, "wd_end",      W0, M_WD);
    exp_at(t0 + 203, "wd2_before",  W0, M_WD);
    exp_at(t0 + 204, "wd2_first",   W1, M_WD);
    exp_at(t0 + 207, "wd2_last",    W1, M_WD);
    exp_at(t0 + 208, "wd2_end",     W0, M_WD);

    for (int i = 0; i < 6; i++) begin
      IOCS = 1'b0; RWb = 1'b1; ADDR = RD_A[i];
      rq_e.push_back(RD_E[i]); rq_a.push_back(int'(RD_A[i]));
      step();
    end
    IOCS = 1'b1;
    exp_at(cyc + 1, "rd_idle", mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0), M_RD);
    step();

    cpu_write(4'hC, 8'h5A, 1'b0, e);
    exp_at(e, "snd_wr", mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0), M_SND);
    SNDACK = 1'b1;
    step();
    SNDACK = 1'b0;
    exp_at(cyc, "snd_ack", mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0), M_SND);
    step();
    cpu_write(4'hC, 8'h11, 1'b1, e);
    exp_at(e, "snd_set_wins", mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0), M_SND);

    // Kicks every 50 cycles, then one landing exactly on the limit cycle.
    wait_until(t0 + 212);
    cpu_write(4'h8, 8'h00, 1'b0, k1);
    for (int c = k1; c < k1 + 400; c++) exp_at(c, "wd_kicked", W0, M_WD);
    exp_at(k1 + 400, "wd_alive", W1, M_WD);
    for (int j = 1; j <= 4; j++) begin
      wait_until(k1 + 50 * j - 2);
      cpu_write(4'h8, 8'h00, 1'b0, e);
    end
    wait_until(k1 + 298);
    cpu_write(4'h8, 8'h00, 1'b0, e);

    // Control write, then CE held steady must not repeat it.
    wait_until(k1 + 406);
    cpu_write(4'h8, 8'h63, 1'b0, c1);
    exp_at(c1, "ctrl_wr", mk(8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0), M_CTRL);
    IOCS = 1'b0; RWb = 1'b0; ADDR = 4'h8; DIN = 8'h00;
    repeat (50) step();
    exp_at(cyc, "hold_lo", mk(8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0), M_CTRL);
    CE = 1'b1;
    repeat (50) step();
    exp_at(cyc, "hold_hi", mk(8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0), M_CTRL);
    IOCS = 1'b1;
    step();
    CE = 1'b0;
    repeat (2) step();
    RWb = 1'b1;
    exp_at(cyc, "cs_gate", mk(8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0), M_CTRL);
    cpu_write(4'h8, 8'h9E, 1'b0, c2);
    exp_at(c2, "ctrl_bits", mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0), M_CTRL);
    cpu_write(4'h9, 8'hFF, 1'b0, c3);
    exp_at(c3, "ign_addr", mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0),
           M_CTRL | M_SND);

    // Reset in the middle of a WDRST pulse with the IRQ pending.
    wait_until(c2 + 101);
    exp_at(cyc, "pre_rst", mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1),
           M_SND | M_WD);
    RESET = 1'b1;
    step();
    exp_at(cyc, "mid_rst", mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0), M_ALL);
    RESET = 1'b0;
    t1 = cyc;
    exp_at(t1 + 99,  "rst_wd_before", W0, M_WD);
    exp_at(t1 + 100, "rst_wd_fire",   W1, M_WD);
    wait_until(t1 + 103);

    for (int i = 0; i < tq_c.size(); i++) begin
      nchk++;
      $display("FAIL %s never checked: due cyc %0d", tq_n[i], tq_c[i]);
    end
    for (int i = 0; i < rq_e.size(); i++) begin
      nchk++;
      $display("FAIL rd_a%0d missing: got no DOE, want DOUT=%h", rq_a[i], rq_e[i]);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
